// File: rtl/matrix_stream_tx.sv
// matrix_stream_tx
// Transmit-side feeder for the matrix inverter. A host fills a square
// element buffer while the block is idle, then pulses start. The block
// streams the N x N elements row-major, one word per clock, waits for the
// inverter's ready level, and reports completion, the invertible flag and
// error status.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   order          matrix order N, sampled on an accepted start
//   wr_en          host write strobe into the element buffer (IDLE only)
//   wr_addr        element address = row*MAX_ORDER + col
//   wr_data        element value
//   start          single-cycle pulse that begins streaming
//   inv_ready      inverter result-ready level
//   inv_invertible inverter invertible flag
//   matrix_data    streamed element (0 when not valid)
//   data_valid     matrix_data is valid this cycle
//   row_idx        row of the element being presented
//   col_idx        column of the element being presented
//   busy           high in any state other than IDLE
//   done           one-cycle pulse on successful completion
//   result_ok      inv_invertible latched at completion
//   err            one-cycle pulse on bad order or ready timeout
module matrix_stream_tx #(
    parameter int DATA_W    = 16,
    parameter int MAX_ORDER = 4,
    parameter int TIMEOUT   = 1024,
    localparam int AW       = $clog2(MAX_ORDER * MAX_ORDER)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        order,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              inv_ready,
    input  logic              inv_invertible,
    output logic [DATA_W-1:0] matrix_data,
    output logic              data_valid,
    output logic [3:0]        row_idx,
    output logic [3:0]        col_idx,
    output logic              busy,
    output logic              done,
    output logic              result_ok,
    output logic              err
);

    localparam int DEPTH = MAX_ORDER * MAX_ORDER;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]    MAX_N     = 4'(MAX_ORDER);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_RDY = 2'd2,
        ST_FINISH   = 2'd3
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] buf_r [DEPTH];
    logic [3:0]        n_r;
    logic [TW-1:0]     tcnt_r;
    logic [3:0]        last_s;
    logic [DATA_W-1:0] first_word_s;

    // Flat buffer index of element (r, c); the buffer pitch is always MAX_ORDER.
    function automatic logic [AW-1:0] elem_idx(input logic [3:0] r, input logic [3:0] c);
        int flat;
        flat = int'(r) * MAX_ORDER + int'(c);
        return flat[AW-1:0];
    endfunction

    // Last row/column index of the latched order, and element (0,0) with a
    // same-cycle host write forwarded so the freshly written value streams.
    always_comb begin
        last_s = n_r - 4'd1;
        if (wr_en && (wr_addr == AW'(0))) begin
            first_word_s = wr_data;
        end else begin
            first_word_s = buf_r[0];
        end
    end

    // Element buffer, control FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            n_r         <= 4'd0;
            tcnt_r      <= '0;
            matrix_data <= '0;
            data_valid  <= 1'b0;
            row_idx     <= 4'd0;
            col_idx     <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_ok   <= 1'b0;
            err         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // Host writes only land while idle; otherwise they are dropped.
            if ((state_r == ST_IDLE) && wr_en) begin
                buf_r[wr_addr] <= wr_data;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start && ((order == 4'd0) || (order > MAX_N))) begin
                        err <= 1'b1;
                    end else if (start) begin
                        n_r         <= order;
                        row_idx     <= 4'd0;
                        col_idx     <= 4'd0;
                        matrix_data <= first_word_s;
                        data_valid  <= 1'b1;
                        busy        <= 1'b1;
                        result_ok   <= 1'b0;
                        state_r     <= ST_STREAM;
                    end else begin
                        matrix_data <= '0;
                        data_valid  <= 1'b0;
                        row_idx     <= 4'd0;
                        col_idx     <= 4'd0;
                        busy        <= 1'b0;
                    end
                end

                ST_STREAM: begin
                    // row_idx/col_idx hold the element on the bus right now;
                    // advance to the next one or leave after (N-1, N-1).
                    if ((row_idx == last_s) && (col_idx == last_s)) begin
                        matrix_data <= '0;
                        data_valid  <= 1'b0;
                        row_idx     <= 4'd0;
                        col_idx     <= 4'd0;
                        tcnt_r      <= '0;
                        state_r     <= ST_WAIT_RDY;
                    end else if (col_idx == last_s) begin
                        row_idx     <= row_idx + 4'd1;
                        col_idx     <= 4'd0;
                        matrix_data <= buf_r[elem_idx(row_idx + 4'd1, 4'd0)];
                    end else begin
                        col_idx     <= col_idx + 4'd1;
                        matrix_data <= buf_r[elem_idx(row_idx, col_idx + 4'd1)];
                    end
                end

                ST_WAIT_RDY: begin
                    // Ready wins over timeout on the same edge.
                    if (inv_ready) begin
                        result_ok <= inv_invertible;
                        done      <= 1'b1;
                        state_r   <= ST_FINISH;
                    end else if (tcnt_r == TCNT_LAST) begin
                        err       <= 1'b1;
                        result_ok <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end

                ST_FINISH: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    matrix_data <= '0;
                    data_valid  <= 1'b0;
                    row_idx     <= 4'd0;
                    col_idx     <= 4'd0;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Self-checking bench for matrix_stream_tx: a table of scenarios plus random
// runs, each checked cycle by cycle against a model that derives the expected
// stream and status timing from the matrix contents and the ready delay.
module tb_matrix_stream_tx;

    localparam int DW = 16;
    localparam int MO = 4;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    order;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          inv_ready;
    logic          inv_invertible;
    logic [DW-1:0] matrix_data;
    logic          data_valid;
    logic [3:0]    row_idx;
    logic [3:0]    col_idx;
    logic          busy;
    logic          done;
    logic          result_ok;
    logic          err;

    int            n_pass  = 0;
    int            n_total = 0;
    logic [DW-1:0] mem [16];
    bit            ok_model;

    typedef struct {
        int order;
        int dly;
        bit inv;
        int fill;   // 0 none, 1 values 1..9 in the 3x3 corner, 2 random
        bit e_done;
        bit e_err;
        bit e_ok;
    } vec_t;

    vec_t vecs [10];

    matrix_stream_tx #(.DATA_W(DW), .MAX_ORDER(MO), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .order(order), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .inv_ready(inv_ready),
        .inv_invertible(inv_invertible), .matrix_data(matrix_data),
        .data_valid(data_valid), .row_idx(row_idx), .col_idx(col_idx),
        .busy(busy), .done(done), .result_ok(result_ok), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [28:0] outs();
        return {data_valid, matrix_data, row_idx, col_idx, busy, done, result_ok, err};
    endfunction

    function automatic logic [28:0] pack(bit v, logic [DW-1:0] d, int r, int c,
                                         bit b, bit dn, bit ok, bit e);
        return {v, d, 4'(r), 4'(c), b, dn, ok, e};
    endfunction

    task automatic chk(input string name, input logic [28:0] act, input logic [28:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {v,data,row,col,busy,done,ok,err}=%h expected %h",
                      name, act, exp);
    endtask

    task automatic write_mem(input int addr, input logic [DW-1:0] val);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = val;
        @(negedge clk);
        wr_en   = 1'b0;
        mem[addr] = val;
    endtask

    task automatic fill_mem(input int mode);
        if (mode == 1) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    write_mem(r * MO + c, 16'(r * 3 + c + 1));
        end else if (mode == 2) begin
            for (int a = 0; a < 16; a++) write_mem(a, 16'($urandom));
        end
    endtask

    // One start pulse and everything that must follow it, checked each cycle.
    // Cycle c is the interval after the c-th rising edge following start.
    task automatic run_case(input int id, input int ord, input int dly, input bit inv,
                            input bit e_done, input bit e_err, input bit e_ok,
                            input int inj, input bit sw, input logic [DW-1:0] swv);
        bit good, v, eok;
        int nn, done_c, err_c, end_c, busy_end, r, cc;
        logic [DW-1:0] d;
        good     = (ord >= 1) && (ord <= MO);
        nn       = good ? ord * ord : 0;
        done_c   = (good && e_done) ? nn + 2 + dly : -1;
        err_c    = !good ? 1 : (e_err ? nn + 1 + TO : -1);
        end_c    = (done_c > 0) ? done_c : err_c;
        busy_end = (done_c > 0) ? done_c : err_c - 1;
        order = 4'(ord);
        start = 1'b1;
        if (sw) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = swv; mem[0] = swv;
        end
        for (int c = 1; c <= end_c + 2; c++) begin
            @(negedge clk);
            v = good && (c <= nn);
            d = '0; r = 0; cc = 0;
            if (v) begin
                r  = (c - 1) / ord;
                cc = (c - 1) % ord;
                d  = mem[r * MO + cc];
            end
            if (good) eok = (done_c > 0 && c >= done_c) ? inv : 1'b0;
            else eok = ok_model;
            chk($sformatf("case%0d cyc%0d", id, c), outs(),
                pack(v, d, r, cc, good && (c <= busy_end), c == done_c, eok, c == err_c));
            start = 1'b0;
            wr_en = 1'b0;
            inv_ready      = good && (c >= nn + 1 + dly) && (done_c < 0 || c < done_c);
            inv_invertible = inv;
            if (c == inj) begin
                start = 1'b1; order = 4'd2;
                wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
            end
        end
        inv_ready = 1'b0;
        chk($sformatf("case%0d final result_ok", id), {28'd0, result_ok}, {28'd0, e_ok});
        ok_model = e_ok;
    endtask

    initial begin
        vecs[0] = '{3, 20,   1'b1, 1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{0, 0,    1'b0, 0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{5, 0,    1'b0, 0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{2, 1000, 1'b1, 2, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4, 0,    1'b1, 2, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1, 3,    1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{4, 31,   1'b1, 2, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{2, 32,   1'b1, 2, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{3, 7,    1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{15, 0,   1'b1, 0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; order = 4'd0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = '0;
        start = 1'b0; inv_ready = 1'b0; inv_invertible = 1'b0;
        for (int a = 0; a < 16; a++) mem[a] = '0;
        ok_model = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset state", outs(), '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle after reset", outs(), '0);

        for (int i = 0; i < 10; i++) begin
            fill_mem(vecs[i].fill);
            run_case(i, vecs[i].order, vecs[i].dly, vecs[i].inv,
                     vecs[i].e_done, vecs[i].e_err, vecs[i].e_ok, 0, 1'b0, '0);
        end

        for (int i = 0; i < 6; i++) begin
            int ord, dly;
            bit inv;
            ord = int'($urandom_range(1, 4));
            dly = int'($urandom_range(0, 40));
            inv = 1'($urandom_range(0, 1));
            fill_mem(2);
            run_case(100 + i, ord, dly, inv, dly < TO, dly >= TO,
                     (dly < TO) ? inv : 1'b0, 0, 1'b0, '0);
        end

        // Write to element 0 in the same cycle as start: the new value streams.
        run_case(200, 2, 0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 16'h1234);
        // Write and start while streaming are both ignored.
        fill_mem(2);
        write_mem(0, 16'h0ABC);
        run_case(201, 3, 2, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b0, '0);
        run_case(202, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, '0);

        // Reset after four of nine words: outputs clear, buffer clears.
        fill_mem(1);
        order = 4'd3;
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("rst-seq word%0d", c), outs(),
                pack(1'b1, mem[((c - 1) / 3) * MO + (c - 1) % 3], (c - 1) / 3, (c - 1) % 3,
                     1'b1, 1'b0, 1'b0, 1'b0));
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst-seq after reset", outs(), '0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst-seq idle", outs(), '0);
        for (int a = 0; a < 16; a++) mem[a] = '0;
        ok_model = 1'b0;
        run_case(300, 3, 0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/matrix_stream_tx.md
Name: matrix_stream_tx

Overview:
Transmit-side feeder for the matrix inverter. It buffers one square matrix written by a host port, then streams the elements row-major, one word per clock, onto the inverter's serial matrix_data input. It then waits for the inverter's ready, and reports completion, the invertible flag and timeout/error status back to the host.

Parameters:
DATA_W, 16, element width (signed fixed-point, passed through unmodified)
MAX_ORDER, 4, largest supported matrix order
TIMEOUT, 1024, max cycles to wait for inv_ready after the last element

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
order  in  4  matrix order N, sampled on accepted start
wr_en  in  1  host write strobe into element buffer
wr_addr  in  $clog2(MAX_ORDER*MAX_ORDER)  element address = row*MAX_ORDER + col
wr_data  in  DATA_W  element value
start  in  1  begin streaming (single-cycle pulse)
inv_ready  in  1  inverter result-ready level
inv_invertible  in  1  inverter invertible flag
matrix_data  out  DATA_W  streamed element
data_valid  out  1  matrix_data is valid this cycle
row_idx  out  4  row of current element
col_idx  out  4  column of current element
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on successful completion
result_ok  out  1  latched inv_invertible at completion
err  out  1  one-cycle pulse on bad order or timeout

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; all outputs 0; element buffer cleared to 0; counters 0. Reset mid-stream aborts immediately and produces no done or err.
- Element buffer: MAX_ORDER*MAX_ORDER x DATA_W registers.
  - A write takes effect at the clk edge where wr_en=1, only in IDLE.
  - Writes in any other state are ignored.
  - Writing and starting in the same cycle: the write lands first, and the new value is streamed.
- FSM states: IDLE, STREAM, WAIT_RDY, FINISH.
- IDLE, on start=1:
  - If order==0 or order>MAX_ORDER: err pulses the next cycle, state stays IDLE.
  - Otherwise: latch N=order, clear row/col, go to STREAM.
- STREAM:
  - Entered at the edge after start. The first element (0,0) is presented with data_valid=1 in that cycle. Latency from start to the first valid word is 1 cycle.
  - One element per cycle, with no gaps and no backpressure.
  - matrix_data = buf[row*MAX_ORDER+col]; row_idx/col_idx track the element being presented.
  - col increments; when col==N-1, col wraps to 0 and row increments.
  - After element (N-1,N-1): go to WAIT_RDY and clear the timeout counter.
  - Exactly N*N valid cycles.
- WAIT_RDY:
  - data_valid=0; matrix_data=0.
  - If inv_ready=1 (level, sampled each edge): latch result_ok=inv_invertible, go to FINISH.
  - Otherwise, increment the timeout counter. On reaching TIMEOUT-1 without ready: err pulses, result_ok=0, go to IDLE.
- FINISH: done=1 for exactly one cycle, then IDLE. result_ok holds until the next accepted start, which clears it.
- start outside IDLE is ignored.
- data_valid=0 implies matrix_data=0, row_idx=0, col_idx=0.
- N=1: a single valid cycle carrying buf[0], then WAIT_RDY.
- inv_ready already high on entry to WAIT_RDY: completes on the first WAIT_RDY edge, so done comes 2 cycles after the last element.
- All outputs are registered.

Test Plan:
- Reset, write 3x3 values 1..9 to addrs 0,1,2,4,5,6,8,9,10, pulse start with order=3 -> data_valid high for exactly 9 cycles starting the cycle after start; matrix_data 1..9 in order; row/col (0,0),(0,1),(0,2),(1,0)...(2,2).
- After the 3x3 stream, hold inv_ready=0 for 20 cycles, then raise it with inv_invertible=1 -> done one-cycle pulse; result_ok=1; busy falls the cycle after done.
- start with order=0, then with order=5 (MAX_ORDER=4) -> err pulse each time; busy stays 0; data_valid never asserts.
- order=2 stream, inv_ready never asserted, TIMEOUT=16 -> err pulses; result_ok=0; back to IDLE; no done.
- Mid-stream, after 4 of 9 words, assert rst for one cycle -> next cycle all outputs 0 and state IDLE; a subsequent start streams 0 for all elements (buffer cleared).
- During STREAM, assert wr_en to addr 0 with 0xFFFF and pulse start -> both ignored; stream unchanged; order=1 run then emits single word buf[0] with data_valid high for exactly one cycle.
